// File: rtl/exec_pkg.sv
// Shared encodings for the execute/memory slice: ALU control codes, ALUOp
// values and the Funct/Opcode values the ALU-control decode recognises.
package exec_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0001;
    localparam logic [3:0] FUNCT_AND = 4'b0010;
    localparam logic [3:0] FUNCT_OR  = 4'b0011;
    localparam logic [3:0] FUNCT_XOR = 4'b0100;
    localparam logic [3:0] FUNCT_SLT = 4'b0101;
    localparam logic [3:0] FUNCT_SLL = 4'b0110;
    localparam logic [3:0] FUNCT_SRL = 4'b0111;

    localparam logic [3:0] OPC_ADDI = 4'b0100;
    localparam logic [3:0] OPC_SUBI = 4'b0101;
    localparam logic [3:0] OPC_ANDI = 4'b0110;
    localparam logic [3:0] OPC_ORI  = 4'b0111;
    localparam logic [3:0] OPC_SLTI = 4'b1000;

endpackage

// File: rtl/exec_mem_unit_byte_ram24.sv
// Byte-addressed data memory holding big-endian 24-bit words; every access
// touches three consecutive bytes, wrapping at the end of the array.
module byte_ram24 #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [23:0]       wdata_i,
    output logic [23:0]       rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;

    // Address arithmetic is done at ADDR_W bits so the top byte wraps to 0.
    assign addr1 = addr_i + ADDR_W'(1);
    assign addr2 = addr_i + ADDR_W'(2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i[23:16];
            mem_q[addr1]  <= wdata_i[15:8];
            mem_q[addr2]  <= wdata_i[7:0];
        end
    end

    assign rdata_o = re_i ? {mem_q[addr_i], mem_q[addr1], mem_q[addr2]} : 24'h000000;

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the 24-bit single-cycle CPU: ALU-control decode,
// combinational ALU and the data memory addressed by the ALU result.
module exec_mem_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        aluOp_i,
    input  logic [3:0]        funct_i,
    input  logic [3:0]        opcode_i,
    input  logic [3:0]        shamt_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] writeData_i,
    input  logic              memWrite_i,
    input  logic              memRead_i,
    output logic [3:0]        aluCtrl_o,
    output logic [DATA_W-1:0] aluResult_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              carryOut_o,
    output logic [DATA_W-1:0] readData_o
);

    logic [3:0]        aluCtrl;
    logic              bNegate;
    logic [DATA_W-1:0] bOperand;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              carry;

    always_comb begin
        aluCtrl = ALU_ADD;
        case (aluOp_i)
            ALUOP_ADD: aluCtrl = ALU_ADD;
            ALUOP_SUB: aluCtrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: aluCtrl = ALU_ADD;
                    FUNCT_SUB: aluCtrl = ALU_SUB;
                    FUNCT_AND: aluCtrl = ALU_AND;
                    FUNCT_OR:  aluCtrl = ALU_OR;
                    FUNCT_XOR: aluCtrl = ALU_XOR;
                    FUNCT_SLT: aluCtrl = ALU_SLT;
                    FUNCT_SLL: aluCtrl = ALU_SLL;
                    FUNCT_SRL: aluCtrl = ALU_SRL;
                    default:   aluCtrl = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode_i)
                    OPC_ADDI: aluCtrl = ALU_ADD;
                    OPC_SUBI: aluCtrl = ALU_SUB;
                    OPC_ANDI: aluCtrl = ALU_AND;
                    OPC_ORI:  aluCtrl = ALU_OR;
                    OPC_SLTI: aluCtrl = ALU_SLT;
                    default:  aluCtrl = ALU_ADD;
                endcase
            end
            default: aluCtrl = ALU_ADD;
        endcase
    end

    // Subtraction reuses the adder: invert B and inject Bnegate as carry-in.
    always_comb begin
        bNegate  = aluCtrl[3];
        bOperand = bNegate ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, bOperand} + {{DATA_W{1'b0}}, bNegate};
        result   = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (aluCtrl)
            ALU_ADD, ALU_SUB: begin
                result   = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                overflow = (a_i[DATA_W-1] == bOperand[DATA_W-1]) &&
                           (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_AND: result = a_i & b_i;
            ALU_OR:  result = a_i | b_i;
            ALU_XOR: result = a_i ^ b_i;
            ALU_SLL: result = a_i << shamt_i;
            ALU_SRL: result = a_i >> shamt_i;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result = '0;
        endcase
    end

    assign aluCtrl_o   = aluCtrl;
    assign aluResult_o = result;
    assign zero_o      = (result == '0);
    assign overflow_o  = overflow;
    assign carryOut_o  = carry;

    byte_ram24 #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (result[ADDR_W-1:0]),
        .we_i    (memWrite_i),
        .re_i    (memRead_i),
        .wdata_i (writeData_i),
        .rdata_o (readData_o)
    );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: expected values are queued as each
// vector is driven and compared once the combinational outputs settle.
module tb_exec_mem_unit;

    localparam int SEL_CTRL  = 0;
    localparam int SEL_RES   = 1;
    localparam int SEL_ZERO  = 2;
    localparam int SEL_OVF   = 3;
    localparam int SEL_CARRY = 4;
    localparam int SEL_RDATA = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [23:0] value;
    } expItem_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  aluOp;
    logic [3:0]  funct;
    logic [3:0]  opcode;
    logic [3:0]  shamt;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [3:0]  aluCtrl;
    logic [23:0] aluResult;
    logic        zero;
    logic        overflow;
    logic        carryOut;
    logic [23:0] readData;

    expItem_t sbQueue[$];
    int vectorsApplied = 0;
    int miscompares    = 0;

    exec_mem_unit #(
        .DATA_W (24),
        .ADDR_W (8)
    ) dut (
        .clk_i       (clock),
        .rst_i       (reset),
        .aluOp_i     (aluOp),
        .funct_i     (funct),
        .opcode_i    (opcode),
        .shamt_i     (shamt),
        .a_i         (a),
        .b_i         (b),
        .writeData_i (writeData),
        .memWrite_i  (memWrite),
        .memRead_i   (memRead),
        .aluCtrl_o   (aluCtrl),
        .aluResult_o (aluResult),
        .zero_o      (zero),
        .overflow_o  (overflow),
        .carryOut_o  (carryOut),
        .readData_o  (readData)
    );

    always #5 clock = ~clock;

    // ALU-control tables written out independently of the RTL package.
    function automatic logic [3:0] refCtrl(input logic [1:0] op, input logic [3:0] f,
                                           input logic [3:0] o);
        logic [3:0] c;
        c = 4'b0010;
        if (op == 2'b01) c = 4'b1010;
        else if (op == 2'b10) begin
            case (f)
                4'd0: c = 4'b0010;
                4'd1: c = 4'b1010;
                4'd2: c = 4'b0000;
                4'd3: c = 4'b0001;
                4'd4: c = 4'b0011;
                4'd5: c = 4'b1011;
                4'd6: c = 4'b0100;
                4'd7: c = 4'b0101;
                default: c = 4'b0010;
            endcase
        end else if (op == 2'b11) begin
            case (o)
                4'd4: c = 4'b0010;
                4'd5: c = 4'b1010;
                4'd6: c = 4'b0000;
                4'd7: c = 4'b0001;
                4'd8: c = 4'b1011;
                default: c = 4'b0010;
            endcase
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] f, input logic [3:0] o,
                                 input logic [3:0] sh, input logic [23:0] va, input logic [23:0] vb,
                                 input logic [23:0] wd, input logic mw, input logic mr);
        aluOp     = op;
        funct     = f;
        opcode    = o;
        shamt     = sh;
        a         = va;
        b         = vb;
        writeData = wd;
        memWrite  = mw;
        memRead   = mr;
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [23:0] value);
        expItem_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    function automatic logic [23:0] observe(input int sel);
        case (sel)
            SEL_CTRL:  return {20'h0, aluCtrl};
            SEL_RES:   return aluResult;
            SEL_ZERO:  return {23'h0, zero};
            SEL_OVF:   return {23'h0, overflow};
            SEL_CARRY: return {23'h0, carryOut};
            default:   return readData;
        endcase
    endfunction

    task automatic drainScoreboard();
        expItem_t e;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput(e.tag, observe(e.sel), e.value);
        end
    endtask

    task automatic aluVector(input string tag, input logic [1:0] op, input logic [3:0] f,
                             input logic [3:0] sh, input logic [23:0] va, input logic [23:0] vb,
                             input logic [23:0] res, input logic z, input logic ovf,
                             input logic cy);
        applyStimulus(op, f, 4'h0, sh, va, vb, 24'h0, 1'b0, 1'b0);
        expectOut({tag, ".res"}, SEL_RES, res);
        expectOut({tag, ".zero"}, SEL_ZERO, {23'h0, z});
        expectOut({tag, ".ovf"}, SEL_OVF, {23'h0, ovf});
        expectOut({tag, ".carry"}, SEL_CARRY, {23'h0, cy});
        #1;
        drainScoreboard();
    endtask

    // Store through the ADD path: address = a + 0, committed on the next rising edge.
    task automatic storeWord(input logic [23:0] addr, input logic [23:0] wd);
        @(negedge clock);
        applyStimulus(2'b00, 4'h0, 4'h0, 4'h0, addr, 24'h0, wd, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        memWrite = 1'b0;
    endtask

    task automatic loadCheck(input string tag, input logic [23:0] addr, input logic mr,
                             input logic [23:0] expected);
        applyStimulus(2'b00, 4'h0, 4'h0, 4'h0, addr, 24'h0, 24'h0, 1'b0, mr);
        expectOut(tag, SEL_RDATA, expected);
        #1;
        drainScoreboard();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(2'b00, 4'h0, 4'h0, 4'h0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0);
        #12;
        reset = 1'b0;

        loadCheck("reset.load10", 24'h000010, 1'b1, 24'h000000);

        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 16; f++) begin
                for (int o = 0; o < 16; o++) begin
                    applyStimulus(2'(op), 4'(f), 4'(o), 4'h0, 24'h0, 24'h0, 24'h0, 1'b0, 1'b0);
                    expectOut($sformatf("decode.op%0d.f%0d.o%0d", op, f, o), SEL_CTRL,
                              {20'h0, refCtrl(2'(op), 4'(f), 4'(o))});
                    #1;
                    drainScoreboard();
                end
            end
        end

        aluVector("add.ovf",   2'b00, 4'h0, 4'h0, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b1, 1'b0);
        aluVector("add.carry", 2'b00, 4'h0, 4'h0, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0, 1'b1);
        aluVector("sub.eq",    2'b01, 4'h0, 4'h0, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b0, 1'b1);
        aluVector("sub.borrow",2'b01, 4'h0, 4'h0, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
        aluVector("and",       2'b10, 4'h2, 4'h0, 24'hF0F0F0, 24'h0FF0FF, 24'h00F0F0, 1'b0, 1'b0, 1'b0);
        aluVector("or",        2'b10, 4'h3, 4'h0, 24'hF00000, 24'h00000F, 24'hF0000F, 1'b0, 1'b0, 1'b0);
        aluVector("xor",       2'b10, 4'h4, 4'h0, 24'hFF00FF, 24'hFFFF00, 24'h00FFFF, 1'b0, 1'b0, 1'b0);
        aluVector("slt.neg",   2'b10, 4'h5, 4'h0, 24'h800000, 24'h000001, 24'h000001, 1'b0, 1'b0, 1'b0);
        aluVector("slt.pos",   2'b10, 4'h5, 4'h0, 24'h000001, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0);
        aluVector("sll15",     2'b10, 4'h6, 4'hF, 24'h000001, 24'hFFFFFF, 24'h008000, 1'b0, 1'b0, 1'b0);
        aluVector("srl4",      2'b10, 4'h7, 4'h4, 24'h800000, 24'h123456, 24'h080000, 1'b0, 1'b0, 1'b0);

        storeWord(24'h000010, 24'hABCDEF);
        loadCheck("mem.load10", 24'h000010, 1'b1, 24'hABCDEF);
        loadCheck("mem.load11", 24'h000011, 1'b1, 24'hCDEF00);
        loadCheck("mem.noread", 24'h000010, 1'b0, 24'h000000);

        storeWord(24'h0000FE, 24'h123456);
        loadCheck("wrap.loadFE", 24'h0000FE, 1'b1, 24'h123456);
        loadCheck("wrap.loadFF", 24'h0000FF, 1'b1, 24'h345600);
        loadCheck("wrap.load00", 24'h000000, 1'b1, 24'h560000);

        // Simultaneous read and write: old contents before the edge, new after.
        @(negedge clock);
        applyStimulus(2'b00, 4'h0, 4'h0, 4'h0, 24'h000020, 24'h0, 24'h111111, 1'b1, 1'b1);
        expectOut("rw.before", SEL_RDATA, 24'h000000);
        #1;
        drainScoreboard();
        @(posedge clock);
        #1;
        memWrite = 1'b0;
        expectOut("rw.after", SEL_RDATA, 24'h111111);
        drainScoreboard();

        // Reset pulse entirely between rising edges.
        @(negedge clock);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        loadCheck("rst.load10", 24'h000010, 1'b1, 24'h000000);
        loadCheck("rst.loadFE", 24'h0000FE, 1'b1, 24'h000000);
        loadCheck("rst.load00", 24'h000000, 1'b1, 24'h000000);
        loadCheck("rst.load20", 24'h000020, 1'b1, 24'h000000);

        // A write attempted while reset is held must not land.
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(2'b00, 4'h0, 4'h0, 4'h0, 24'h000010, 24'h0, 24'h777777, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        expectOut("rst.duringWrite", SEL_RDATA, 24'h000000);
        drainScoreboard();
        @(negedge clock);
        memWrite = 1'b0;
        reset    = 1'b0;
        loadCheck("rst.afterWrite", 24'h000010, 1'b1, 24'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
